// File: rtl/ocp_slave_mem.sv
// OCP 2.2 slave endpoint with a small word-addressed memory.
// It accepts single and precise incrementing bursts: writes are posted, and
// reads return after a fixed latency. Programmable wait states on SCmdAccept
// precede the first beat of each burst.
module ocp_slave_mem #(
    parameter int MADDR_WIDTH = 64,
    parameter int MDATA_WIDTH = 8,
    parameter int MEM_AW      = 4,
    parameter int ADDR_SHIFT  = 2,
    parameter int ACCEPT_WAIT = 0,
    parameter int RD_LAT      = 1
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic [MADDR_WIDTH-1:0] MAddr,
    input  logic [2:0]             MCmd,
    input  logic [MDATA_WIDTH-1:0] MData,
    input  logic [9:0]             MBurstLength,
    input  logic                   MReqLast,
    output logic                   SCmdAccept,
    output logic [1:0]             SResp,
    output logic [MDATA_WIDTH-1:0] SData,
    output logic                   SRespLast,
    output logic                   proto_err
);

    localparam int DEPTH = 1 << MEM_AW;

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;

    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_e;

    typedef struct packed {
        logic [1:0]             resp;
        logic [MDATA_WIDTH-1:0] data;
        logic                   last;
    } rsp_t;

    state_e                 state_q, state_d;
    logic [2:0]             wait_q, wait_d;
    logic [9:0]             len_q, len_d;
    logic [9:0]             cnt_q, cnt_d;
    logic                   proto_err_q, proto_err_d;
    logic [MDATA_WIDTH-1:0] sdata_q, sdata_d;
    logic [MDATA_WIDTH-1:0] mem_q [DEPTH];
    logic [MDATA_WIDTH-1:0] mem_d [DEPTH];
    rsp_t                   pipe_q [RD_LAT];
    rsp_t                   pipe_d [RD_LAT];

    logic [MADDR_WIDTH-1:0] word_idx;
    logic                   in_range;
    logic [MEM_AW-1:0]      mem_idx;

    logic       cmd_valid, is_wr, is_rd, first_beat, beat_last, accept;
    logic [9:0] req_len, beat_len, beat_pos;
    rsp_t       new_rsp;

    // Word index from the byte address; any index bit above the array is out of range.
    assign word_idx = MAddr >> ADDR_SHIFT;
    assign in_range = (word_idx >> MEM_AW) == '0;
    assign mem_idx  = word_idx[MEM_AW-1:0];

    // Beat qualification: acceptance, burst length and position of the current beat.
    always_comb begin
        // NOTE: every signal written here gets a default before any branch, so no path can leave one unassigned and infer a latch.
        cmd_valid  = MCmd != CMD_IDLE;
        is_wr      = MCmd == CMD_WR;
        is_rd      = MCmd == CMD_RD;
        req_len    = 10'd1;
        if ((is_wr || is_rd) && MBurstLength != 10'd0) begin
            req_len = MBurstLength;
        end
        first_beat = state_q != S_BURST;
        beat_len   = first_beat ? req_len : len_q;
        beat_pos   = first_beat ? 10'd1 : cnt_q + 10'd1;
        beat_last  = beat_pos == beat_len;
        accept     = 1'b0;
        case (state_q)
            S_IDLE:  accept = cmd_valid && (ACCEPT_WAIT == 0);
            S_WAIT:  accept = cmd_valid && (wait_q == 3'd0);
            S_BURST: accept = cmd_valid;
            default: accept = 1'b0;
        endcase
        if (reset) begin
            accept = 1'b0;
        end
    end

    assign SCmdAccept = accept;

    // Next state: wait-state countdown, burst beat counting and protocol check.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        proto_err_d = proto_err_q;
        case (state_q)
            S_IDLE: begin
                // The idle cycle itself is the first wait cycle, hence the -1.
                if (cmd_valid && ACCEPT_WAIT != 0) begin
                    state_d = S_WAIT;
                    wait_d  = 3'(ACCEPT_WAIT - 1);
                end
            end
            S_WAIT: begin
                if (!cmd_valid) begin
                    state_d = S_IDLE;
                end else if (wait_q != 3'd0) begin
                    wait_d = wait_q - 3'd1;
                end
            end
            default: ;
        endcase
        if (accept) begin
            if (MReqLast != beat_last) begin
                proto_err_d = 1'b1;
            end
            if (beat_last) begin
                state_d = S_IDLE;
                cnt_d   = 10'd0;
            end else begin
                state_d = S_BURST;
                cnt_d   = beat_pos;
                len_d   = beat_len;
            end
        end
    end

    // Memory write and response pipeline; a WR never shares a cycle with an RD.
    always_comb begin
        mem_d = mem_q;
        if (accept && is_wr && in_range) begin
            mem_d[mem_idx] = MData;
        end
        new_rsp = '0;
        if (accept && !is_wr) begin
            if (is_rd && in_range) begin
                new_rsp.resp = RESP_DVA;
                new_rsp.data = mem_q[mem_idx];
                new_rsp.last = beat_last;
            end else if (is_rd) begin
                new_rsp.resp = RESP_ERR;
                new_rsp.last = beat_last;
            end else begin
                new_rsp.resp = RESP_ERR;
                new_rsp.last = 1'b1;
            end
        end
        pipe_d[0] = new_rsp;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        sdata_d = (pipe_d[RD_LAT-1].resp != RESP_NULL) ? pipe_d[RD_LAT-1].data : sdata_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking (<=) so every flop samples its pre-edge _d value regardless of statement order.
        if (reset) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
            sdata_q     <= '0;
            // NOTE: the array is small flop storage that must read back 0 after reset, so it is cleared with the rest of the state.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
            sdata_q     <= sdata_d;
            mem_q       <= mem_d;
            pipe_q      <= pipe_d;
        end
    end

    assign SResp     = pipe_q[RD_LAT-1].resp;
    assign SRespLast = pipe_q[RD_LAT-1].last;
    assign SData     = sdata_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Bench for ocp_slave_mem. The main instance has no wait states and RD_LAT=1.
// The second instance has ACCEPT_WAIT=3 and RD_LAT=2. Stimulus comes from
// vector tables, from random bursts checked against a behavioural model,
// and from hand sequences for protocol errors and for reset in mid-burst.
module tb_ocp_slave_mem;

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;
    localparam logic [2:0] CMD_RDEX = 3'b011;
    localparam logic [1:0] R_NULL   = 2'b00;
    localparam logic [1:0] R_DVA    = 2'b01;
    localparam logic [1:0] R_ERR    = 2'b11;
    localparam int         MAIN_LAT = 1;

    logic Clk = 1'b0;
    logic reset;
    always #5 Clk = ~Clk;

    logic [63:0] m_addr;  logic [2:0] m_cmd;  logic [7:0] m_data;  logic [9:0] m_bl;  logic m_last;
    logic        s_acc;   logic [1:0] s_resp; logic [7:0] s_data;  logic s_last;      logic s_perr;
    logic [63:0] w_addr;  logic [2:0] w_cmd;  logic [7:0] w_data;  logic [9:0] w_bl;  logic w_last;
    logic        ws_acc;  logic [1:0] ws_resp; logic [7:0] ws_data; logic ws_last;    logic ws_perr;

    ocp_slave_mem #(.ACCEPT_WAIT(0), .RD_LAT(MAIN_LAT)) dut (
        .Clk(Clk), .reset(reset), .MAddr(m_addr), .MCmd(m_cmd), .MData(m_data),
        .MBurstLength(m_bl), .MReqLast(m_last), .SCmdAccept(s_acc), .SResp(s_resp),
        .SData(s_data), .SRespLast(s_last), .proto_err(s_perr));

    ocp_slave_mem #(.ACCEPT_WAIT(3), .RD_LAT(2)) dut_w (
        .Clk(Clk), .reset(reset), .MAddr(w_addr), .MCmd(w_cmd), .MData(w_data),
        .MBurstLength(w_bl), .MReqLast(w_last), .SCmdAccept(ws_acc), .SResp(ws_resp),
        .SData(ws_data), .SRespLast(ws_last), .proto_err(ws_perr));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0] cmd; logic [63:0] addr; logic [7:0] data; logic [9:0] bl; logic last;
        logic acc; logic [1:0] resp; logic [7:0] sdata; logic rlast;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] c, input logic [63:0] a, input logic [7:0] d,
                                input logic [9:0] b, input logic l, input logic acc,
                                input logic [1:0] r, input logic [7:0] sd, input logic rl);
        vec_t v;
        v.cmd = c; v.addr = a; v.data = d; v.bl = b; v.last = l;
        v.acc = acc; v.resp = r; v.sdata = sd; v.rlast = rl;
        return v;
    endfunction

    task automatic drive_main(input logic [2:0] c, input logic [63:0] a, input logic [7:0] d,
                              input logic [9:0] b, input logic l);
        m_cmd = c; m_addr = a; m_data = d; m_bl = b; m_last = l;
    endtask

    task automatic drive_wait(input logic [2:0] c, input logic [63:0] a, input logic [7:0] d,
                              input logic [9:0] b, input logic l);
        w_cmd = c; w_addr = a; w_data = d; w_bl = b; w_last = l;
    endtask

    // ---------------- behavioural model of the main instance ----------------
    typedef struct { logic [1:0] resp; logic [7:0] data; logic last; } rsp_t;
    logic [7:0] mdl_mem [16];
    rsp_t       line [$];
    rsp_t       cur;
    logic [7:0] exp_sdata;
    logic       exp_perr;
    int         b_pos, b_len;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
        line.delete();
        for (int i = 0; i < MAIN_LAT - 1; i++) line.push_back('{R_NULL, 8'h00, 1'b0});
        cur = '{R_NULL, 8'h00, 1'b0};
        exp_sdata = 8'h00; exp_perr = 1'b0; b_pos = 0; b_len = 0;
    endtask

    task automatic model_step(input logic [2:0] c, input logic [63:0] a, input logic [7:0] d,
                              input logic [9:0] b, input logic l);
        rsp_t        nr;
        logic [63:0] idx;
        bit          is_last;
        nr = '{R_NULL, 8'h00, 1'b0};
        if (c != CMD_IDLE) begin
            if (b_pos == 0) b_len = (c == CMD_WR || c == CMD_RD) ? ((b == 0) ? 1 : int'(b)) : 1;
            b_pos++;
            is_last = (b_pos == b_len);
            if (l != is_last) exp_perr = 1'b1;
            idx = a >> 2;
            if (c == CMD_WR) begin
                if (idx < 16) mdl_mem[idx[3:0]] = d;
            end else if (c == CMD_RD) begin
                nr = (idx < 16) ? '{R_DVA, mdl_mem[idx[3:0]], is_last} : '{R_ERR, 8'h00, is_last};
            end else begin
                nr = '{R_ERR, 8'h00, 1'b1};
            end
            if (is_last) b_pos = 0;
        end
        line.push_back(nr);
        cur = line.pop_front();
        if (cur.resp != R_NULL) exp_sdata = cur.data;
    endtask

    task automatic cycle_main(input logic [2:0] c, input logic [63:0] a, input logic [7:0] d,
                              input logic [9:0] b, input logic l);
        drive_main(c, a, d, b, l);
        #1;
        check("mdl.accept", s_acc, c != CMD_IDLE);
        check("mdl.resp",   s_resp, cur.resp);
        check("mdl.sdata",  s_data, exp_sdata);
        check("mdl.rlast",  s_last, cur.last);
        check("mdl.perr",   s_perr, exp_perr);
        model_step(c, a, d, b, l);
        @(posedge Clk); #1;
    endtask

    task automatic do_reset();
        drive_main(CMD_IDLE, 0, 0, 0, 0);
        drive_wait(CMD_IDLE, 0, 0, 0, 0);
        reset = 1'b1;
        @(posedge Clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    vec_t tab [$];
    vec_t wtab [$];

    initial begin
        logic [2:0]  g_cmd;
        logic [63:0] g_base, g_addr;
        logic [9:0]  g_bl;
        int          g_left, g_pos, r;

        // ---- reset state; an RD held during reset must not be accepted ----
        drive_wait(CMD_IDLE, 0, 0, 0, 0);
        drive_main(CMD_RD, 64'h4, 8'h00, 10'd1, 1'b1);
        reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("rst.accept", s_acc, 1'b0);
        check("rst.resp",   s_resp, R_NULL);
        check("rst.sdata",  s_data, 8'h00);
        check("rst.rlast",  s_last, 1'b0);
        check("rst.perr",   s_perr, 1'b0);
        drive_main(CMD_IDLE, 0, 0, 0, 0);
        reset = 1'b0;
        model_reset();

        // ---- table: single WR/RD, burst WR/RD, out of range, other commands, len 0 ----
        tab.push_back(mk(CMD_WR,   64'h04, 8'hFF, 1, 1, 1, R_NULL, 8'h00, 0));
        tab.push_back(mk(CMD_RD,   64'h04, 8'h00, 1, 1, 1, R_NULL, 8'h00, 0));
        tab.push_back(mk(CMD_IDLE, 64'h00, 8'h00, 0, 0, 0, R_DVA,  8'hFF, 1));
        tab.push_back(mk(CMD_WR,   64'h00, 8'h00, 4, 0, 1, R_NULL, 8'hFF, 0));
        tab.push_back(mk(CMD_WR,   64'h04, 8'h01, 4, 0, 1, R_NULL, 8'hFF, 0));
        tab.push_back(mk(CMD_WR,   64'h08, 8'h02, 4, 0, 1, R_NULL, 8'hFF, 0));
        tab.push_back(mk(CMD_WR,   64'h0C, 8'h03, 4, 1, 1, R_NULL, 8'hFF, 0));
        tab.push_back(mk(CMD_RD,   64'h00, 8'h00, 4, 0, 1, R_NULL, 8'hFF, 0));
        tab.push_back(mk(CMD_RD,   64'h04, 8'h00, 4, 0, 1, R_DVA,  8'h00, 0));
        tab.push_back(mk(CMD_RD,   64'h08, 8'h00, 4, 0, 1, R_DVA,  8'h01, 0));
        tab.push_back(mk(CMD_RD,   64'h0C, 8'h00, 4, 1, 1, R_DVA,  8'h02, 0));
        tab.push_back(mk(CMD_IDLE, 64'h00, 8'h00, 0, 0, 0, R_DVA,  8'h03, 1));
        tab.push_back(mk(CMD_RD,   64'h40, 8'h00, 1, 1, 1, R_NULL, 8'h03, 0));
        tab.push_back(mk(CMD_WR,   64'h40, 8'hAA, 1, 1, 1, R_ERR,  8'h00, 1));
        tab.push_back(mk(CMD_RD,   64'h04, 8'h00, 1, 1, 1, R_NULL, 8'h00, 0));
        tab.push_back(mk(CMD_RD,   64'h00, 8'h00, 1, 1, 1, R_DVA,  8'h01, 1));
        tab.push_back(mk(CMD_IDLE, 64'h00, 8'h00, 0, 0, 0, R_DVA,  8'h00, 1));
        tab.push_back(mk(CMD_RDEX, 64'h00, 8'h00, 3, 1, 1, R_NULL, 8'h00, 0));
        tab.push_back(mk(CMD_IDLE, 64'h00, 8'h00, 0, 0, 0, R_ERR,  8'h00, 1));
        tab.push_back(mk(CMD_WR,   64'h3C, 8'h5A, 0, 1, 1, R_NULL, 8'h00, 0));
        tab.push_back(mk(CMD_RD,   64'h3C, 8'h00, 0, 1, 1, R_NULL, 8'h00, 0));
        tab.push_back(mk(CMD_IDLE, 64'h00, 8'h00, 0, 0, 0, R_DVA,  8'h5A, 1));
        tab.push_back(mk(CMD_IDLE, 64'h00, 8'h00, 0, 0, 0, R_NULL, 8'h5A, 0));
        for (int i = 0; i < tab.size(); i++) begin
            drive_main(tab[i].cmd, tab[i].addr, tab[i].data, tab[i].bl, tab[i].last);
            #1;
            check("tab.accept", s_acc, tab[i].acc);
            check("tab.resp",   s_resp, tab[i].resp);
            check("tab.sdata",  s_data, tab[i].sdata);
            check("tab.rlast",  s_last, tab[i].rlast);
            check("tab.perr",   s_perr, 1'b0);
            @(posedge Clk); #1;
        end

        // ---- wait-state instance: ACCEPT_WAIT=3, RD_LAT=2 ----
        do_reset();
        for (int i = 0; i < 4; i++) wtab.push_back(mk(CMD_WR, 64'h04, 8'h3C, 1, 1, i == 3, R_NULL, 8'h00, 0));
        for (int i = 0; i < 4; i++) wtab.push_back(mk(CMD_RD, 64'h00, 8'h00, 4, 0, i == 3, R_NULL, 8'h00, 0));
        wtab.push_back(mk(CMD_RD,   64'h04, 8'h00, 4, 0, 1, R_NULL, 8'h00, 0));
        wtab.push_back(mk(CMD_RD,   64'h08, 8'h00, 4, 0, 1, R_DVA,  8'h00, 0));
        wtab.push_back(mk(CMD_RD,   64'h0C, 8'h00, 4, 1, 1, R_DVA,  8'h3C, 0));
        wtab.push_back(mk(CMD_IDLE, 64'h00, 8'h00, 0, 0, 0, R_DVA,  8'h00, 0));
        wtab.push_back(mk(CMD_IDLE, 64'h00, 8'h00, 0, 0, 0, R_DVA,  8'h00, 1));
        wtab.push_back(mk(CMD_RD,   64'h04, 8'h00, 1, 1, 0, R_NULL, 8'h00, 0));
        wtab.push_back(mk(CMD_IDLE, 64'h00, 8'h00, 0, 0, 0, R_NULL, 8'h00, 0));
        for (int i = 0; i < 4; i++) wtab.push_back(mk(CMD_RD, 64'h04, 8'h00, 1, 1, i == 3, R_NULL, 8'h00, 0));
        wtab.push_back(mk(CMD_IDLE, 64'h00, 8'h00, 0, 0, 0, R_NULL, 8'h00, 0));
        wtab.push_back(mk(CMD_IDLE, 64'h00, 8'h00, 0, 0, 0, R_DVA,  8'h3C, 1));
        wtab.push_back(mk(CMD_IDLE, 64'h00, 8'h00, 0, 0, 0, R_NULL, 8'h3C, 0));
        for (int i = 0; i < wtab.size(); i++) begin
            drive_wait(wtab[i].cmd, wtab[i].addr, wtab[i].data, wtab[i].bl, wtab[i].last);
            #1;
            check("wait.accept", ws_acc, wtab[i].acc);
            check("wait.resp",   ws_resp, wtab[i].resp);
            check("wait.sdata",  ws_data, wtab[i].sdata);
            check("wait.rlast",  ws_last, wtab[i].rlast);
            check("wait.perr",   ws_perr, 1'b0);
            @(posedge Clk); #1;
        end

        // ---- random legal bursts against the model ----
        do_reset();
        g_left = 0; g_pos = 0; g_cmd = CMD_IDLE; g_base = '0; g_bl = '0;
        for (int c = 0; c < 400; c++) begin
            if ((g_left == 0 && $urandom_range(0, 3) == 0) || (g_left > 0 && $urandom_range(0, 4) == 0)) begin
                cycle_main(CMD_IDLE, 64'($urandom), 8'($urandom), 10'($urandom_range(0, 5)), 1'b0);
            end else begin
                if (g_left == 0) begin
                    r = $urandom_range(0, 99);
                    g_cmd = (r < 45) ? CMD_WR : (r < 85) ? CMD_RD : 3'($urandom_range(3, 7));
                    g_bl  = 10'($urandom_range(0, 5));
                    g_left = (g_cmd == CMD_WR || g_cmd == CMD_RD) ? ((g_bl == 0) ? 1 : int'(g_bl)) : 1;
                    g_pos = 0;
                    r = $urandom_range(0, 9);
                    if (r == 0)      g_base = 64'h40 + 64'($urandom_range(0, 60));
                    else if (r == 1) g_base = 64'h8000_0000_0000_0000 | 64'($urandom_range(0, 15) * 4);
                    else             g_base = 64'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                end
                g_addr = g_base + 64'(4 * g_pos);
                g_pos++;
                g_left--;
                cycle_main(g_cmd, g_addr, 8'($urandom), g_bl, g_left == 0);
            end
        end
        repeat (3) cycle_main(CMD_IDLE, 0, 0, 0, 0);

        // ---- MReqLast on beat 2 of a 4-beat RD: sticky proto_err, burst still completes ----
        do_reset();
        cycle_main(CMD_WR, 64'h0C, 8'hC3, 1, 1);
        cycle_main(CMD_RD, 64'h00, 0, 4, 0);
        cycle_main(CMD_RD, 64'h04, 0, 4, 1);
        cycle_main(CMD_RD, 64'h08, 0, 4, 0);
        cycle_main(CMD_RD, 64'h0C, 0, 4, 0);
        drive_main(CMD_IDLE, 0, 0, 0, 0);
        #1;
        check("perr.resp4",  s_resp, R_DVA);
        check("perr.data4",  s_data, 8'hC3);
        check("perr.last4",  s_last, 1'b1);
        check("perr.sticky", s_perr, 1'b1);
        @(posedge Clk); #1;
        model_step(CMD_IDLE, 0, 0, 0, 0);
        repeat (3) cycle_main(CMD_IDLE, 0, 0, 0, 0);

        // ---- reset after beat 2 of a 4-beat RD ----
        do_reset();
        cycle_main(CMD_WR, 64'h08, 8'h77, 1, 1);
        cycle_main(CMD_RD, 64'h00, 0, 4, 0);
        cycle_main(CMD_RD, 64'h04, 0, 4, 0);
        drive_main(CMD_RD, 64'h08, 0, 4, 0);
        reset = 1'b1;
        #1;
        check("mid.rst_accept", s_acc, 1'b0);
        @(posedge Clk); #1;
        reset = 1'b0;
        model_reset();
        drive_main(CMD_IDLE, 0, 0, 0, 0);
        #1;
        check("mid.accept", s_acc, 1'b0);
        check("mid.resp",   s_resp, R_NULL);
        check("mid.sdata",  s_data, 8'h00);
        check("mid.rlast",  s_last, 1'b0);
        check("mid.perr",   s_perr, 1'b0);
        @(posedge Clk); #1;
        cycle_main(CMD_RD, 64'h08, 0, 1, 1);
        drive_main(CMD_IDLE, 0, 0, 0, 0);
        #1;
        check("mid.rd_resp", s_resp, R_DVA);
        check("mid.rd_data", s_data, 8'h00);
        check("mid.rd_last", s_last, 1'b1);
        check("mid.rd_perr", s_perr, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
